// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: hex glyphs (active-low,
// seg[6:0] = g..a) and active-low digit-enable patterns.
package display_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
        logic [3:0] an_pat;
        an_pat = AN_OFF;
        case (digit)
            2'd0: an_pat = AN_DIG0;
            2'd1: an_pat = AN_DIG1;
            2'd2: an_pat = AN_DIG2;
            2'd3: an_pat = AN_DIG3;
            default: an_pat = AN_OFF;
        endcase
        return an_pat;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/reg_display_scanner.sv
// Register-file display reader: selects a register (manual or auto-scan), snapshots
// its value once per refresh frame and multiplexes 16 bits of it onto 4 hex digits.
module reg_display_scanner
    import display_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int ADDR_W      = 5,
    parameter int REFRESH_DIV = 100000,
    parameter int SCAN_DIV    = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] selReg,
    input  logic              pageSel,
    input  logic              autoScan,
    output logic [ADDR_W-1:0] displayReg,
    input  logic [SIZE-1:0]   displayData,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int RC_W = $clog2(REFRESH_DIV + 1);
    localparam int DC_W = $clog2(SCAN_DIV + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(SCAN_DIV - 1);

    logic [RC_W-1:0] r_rc;
    logic [DC_W-1:0] r_dc;
    logic [1:0]      r_digit;
    logic [SIZE-1:0] r_snap;
    logic            r_page_lat;

    logic            w_tick;
    logic            w_frame;
    logic [15:0]     w_page_half;
    logic [3:0]      w_nibble;
    logic [6:0]      w_glyph;

    assign w_tick      = (r_rc == RC_LAST);
    assign w_frame     = w_tick && (r_digit == 2'd3);
    assign w_page_half = r_page_lat ? r_snap[31:16] : r_snap[15:0];
    assign w_nibble    = w_page_half[{r_digit, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_hex (w_nibble),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rc       <= '0;
            r_dc       <= '0;
            r_digit    <= 2'd0;
            r_snap     <= '0;
            r_page_lat <= 1'b0;
            displayReg <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            r_rc <= w_tick ? '0 : r_rc + 1'b1;
            if (w_tick)
                r_digit <= r_digit + 2'd1;
            // Snapshot only at the frame boundary so all four digits come from one value.
            if (w_frame) begin
                r_snap     <= displayData;
                r_page_lat <= pageSel;
            end

            // Holding dwell at 0 in manual mode gives a fresh dwell on every entry to auto.
            if (!autoScan) begin
                displayReg <= selReg;
                r_dc       <= '0;
            end else if (r_dc == DC_LAST) begin
                displayReg <= displayReg + 1'b1;
                r_dc       <= '0;
            end else begin
                r_dc <= r_dc + 1'b1;
            end

            an  <= an_for_digit(r_digit);
            seg <= w_glyph;
            dp  <= ~(r_page_lat & (r_digit == 2'd3));
        end
    end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with REFRESH_DIV=2, SCAN_DIV=8 and a small
// combinational register-file model.
module tb_reg_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  selReg = 5'd0;
    logic        pageSel = 1'b0;
    logic        autoScan = 1'b0;
    logic [4:0]  displayReg;
    logic [31:0] displayData;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [31:0] reg3_val = 32'h0000000C;
    int ecnt = 0;
    int n_vec = 0;
    int n_err = 0;

    reg_display_scanner #(
        .SIZE(32), .ADDR_W(5), .REFRESH_DIV(2), .SCAN_DIV(8)
    ) dut (
        .clk(clk), .reset(reset), .selReg(selReg), .pageSel(pageSel),
        .autoScan(autoScan), .displayReg(displayReg), .displayData(displayData),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    always_comb begin
        displayData = 32'h0;
        case (displayReg)
            5'd3:  displayData = reg3_val;
            5'd5:  displayData = 32'hDEADBEEF;
            5'd30: displayData = 32'h0000001E;
            5'd31: displayData = 32'h0000001F;
            default: displayData = 32'h0;
        endcase
    end

    // Edge count since reset release; frame boundaries fall on multiples of 8.
    task automatic step();
        @(posedge clk);
        if (reset) ecnt = 0;
        else ecnt++;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sync_frame();
        do step(); while (ecnt % 8 != 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        selReg = 5'd7;
        steps(3);
        n_vec++; if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an got %b want 1111", an); end
        n_vec++; if (seg !== 7'b1111111) begin n_err++; $display("FAIL reset_seg got %b want 1111111", seg); end
        n_vec++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", dp); end
        n_vec++; if (displayReg !== 5'd0) begin n_err++; $display("FAIL reset_displayReg got %0d want 0", displayReg); end
        selReg = 5'd0;
        reset = 1'b0;
        step();
        n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL release_an got %b want 1110", an); end
        n_vec++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL release_seg got %b want 1000000", seg); end
    endtask

    task automatic test_manual();
        logic [6:0] g [4];
        int dig;
        logic [3:0] exp_an;
        g[0] = 7'b1000110; g[1] = 7'b1000000; g[2] = 7'b1000000; g[3] = 7'b1000000;
        selReg = 5'd3; pageSel = 1'b0;
        step();
        n_vec++; if (displayReg !== 5'd3) begin n_err++; $display("FAIL manual_displayReg got %0d want 3", displayReg); end
        sync_frame();
        for (int i = 0; i < 8; i++) begin
            step();
            dig = ((ecnt - 1) / 2) % 4;
            exp_an = 4'b1111; exp_an[dig] = 1'b0;
            n_vec++;
            if (an !== exp_an || seg !== g[dig] || dp !== 1'b1) begin
                n_err++;
                $display("FAIL manual_digit edge %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         ecnt, an, seg, dp, exp_an, g[dig]);
            end
        end
    endtask

    task automatic test_page();
        logic [6:0] g [4];
        int dig;
        logic [3:0] exp_an;
        logic exp_dp;
        g[0] = 7'b0100001; g[1] = 7'b0001000; g[2] = 7'b0000110; g[3] = 7'b0100001;
        selReg = 5'd5; pageSel = 1'b1;
        step();
        n_vec++; if (displayReg !== 5'd5) begin n_err++; $display("FAIL page_displayReg got %0d want 5", displayReg); end
        sync_frame();
        for (int i = 0; i < 8; i++) begin
            step();
            dig = ((ecnt - 1) / 2) % 4;
            exp_an = 4'b1111; exp_an[dig] = 1'b0;
            exp_dp = (dig == 3) ? 1'b0 : 1'b1;
            n_vec++;
            if (an !== exp_an || seg !== g[dig] || dp !== exp_dp) begin
                n_err++;
                $display("FAIL page_digit edge %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         ecnt, an, seg, dp, exp_an, g[dig], exp_dp);
            end
        end
    endtask

    task automatic test_autoscan_wrap();
        pageSel = 1'b0; selReg = 5'd30;
        step();
        n_vec++; if (displayReg !== 5'd30) begin n_err++; $display("FAIL scan_start got %0d want 30", displayReg); end
        // Start the dwell mid-frame so increments never coincide with a frame boundary.
        while (ecnt % 8 != 4) step();
        autoScan = 1'b1;
        steps(5);
        n_vec++; if (an !== 4'b1110 || seg !== 7'b0000110) begin n_err++; $display("FAIL scan_glyph_E got an=%b seg=%b want an=1110 seg=0000110", an, seg); end
        steps(2);
        n_vec++; if (displayReg !== 5'd30) begin n_err++; $display("FAIL scan_hold30 got %0d want 30", displayReg); end
        step();
        n_vec++; if (displayReg !== 5'd31) begin n_err++; $display("FAIL scan_to31 got %0d want 31", displayReg); end
        steps(5);
        n_vec++; if (an !== 4'b1110 || seg !== 7'b0001110) begin n_err++; $display("FAIL scan_glyph_F got an=%b seg=%b want an=1110 seg=0001110", an, seg); end
        steps(2);
        n_vec++; if (displayReg !== 5'd31) begin n_err++; $display("FAIL scan_hold31 got %0d want 31", displayReg); end
        step();
        n_vec++; if (displayReg !== 5'd0) begin n_err++; $display("FAIL scan_wrap0 got %0d want 0", displayReg); end
        steps(5);
        n_vec++; if (an !== 4'b1110 || seg !== 7'b1000000) begin n_err++; $display("FAIL scan_glyph_0 got an=%b seg=%b want an=1110 seg=1000000", an, seg); end
        autoScan = 1'b0; selReg = 5'd3;
        step();
        n_vec++; if (displayReg !== 5'd3) begin n_err++; $display("FAIL scan_exit_manual got %0d want 3", displayReg); end
    endtask

    task automatic test_tear_free();
        logic [6:0] g_old [4];
        logic [6:0] g_new [4];
        int dig;
        logic [3:0] exp_an;
        g_old[0] = 7'b1000110; g_old[1] = 7'b1000000; g_old[2] = 7'b1000000; g_old[3] = 7'b1000000;
        g_new[0] = 7'b0001110; g_new[1] = 7'b1000000; g_new[2] = 7'b1000000; g_new[3] = 7'b1000000;
        reg3_val = 32'h0000000C;
        selReg = 5'd3; pageSel = 1'b0;
        sync_frame();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                reg3_val = 32'h0000000F;
                pageSel = 1'b1;
            end
            dig = ((ecnt - 1) / 2) % 4;
            exp_an = 4'b1111; exp_an[dig] = 1'b0;
            n_vec++;
            if (an !== exp_an || seg !== g_old[dig] || dp !== 1'b1) begin
                n_err++;
                $display("FAIL tear_old edge %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         ecnt, an, seg, dp, exp_an, g_old[dig]);
            end
            if (i == 4) pageSel = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            dig = ((ecnt - 1) / 2) % 4;
            exp_an = 4'b1111; exp_an[dig] = 1'b0;
            n_vec++;
            if (an !== exp_an || seg !== g_new[dig] || dp !== 1'b1) begin
                n_err++;
                $display("FAIL tear_new edge %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         ecnt, an, seg, dp, exp_an, g_new[dig]);
            end
        end
    endtask

    task automatic test_reset_midscan();
        selReg = 5'd31;
        step();
        n_vec++; if (displayReg !== 5'd31) begin n_err++; $display("FAIL mid_sel31 got %0d want 31", displayReg); end
        autoScan = 1'b1;
        steps(5);
        n_vec++; if (displayReg !== 5'd31) begin n_err++; $display("FAIL mid_dwell got %0d want 31", displayReg); end
        reset = 1'b1;
        step();
        n_vec++; if (displayReg !== 5'd0) begin n_err++; $display("FAIL mid_reset_reg got %0d want 0", displayReg); end
        n_vec++; if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin n_err++; $display("FAIL mid_reset_blank got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp); end
        reset = 1'b0;
        step();
        n_vec++; if (an !== 4'b1110 || seg !== 7'b1000000) begin n_err++; $display("FAIL mid_release got an=%b seg=%b want 1110 1000000", an, seg); end
        steps(6);
        n_vec++; if (displayReg !== 5'd0) begin n_err++; $display("FAIL mid_hold0 got %0d want 0", displayReg); end
        step();
        n_vec++; if (displayReg !== 5'd1) begin n_err++; $display("FAIL mid_first_inc got %0d want 1", displayReg); end
        autoScan = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_page();
        test_autoscan_wrap();
        test_tear_free();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_display_scanner.md
# reg_display_scanner

Reader for the register file's display port: drives the register index onto `displayReg` and takes `displayData` back. Shows 16 bits of the 32-bit register value as hex on a 4-digit multiplexed, active-low seven-segment display. Selection is either manual, from switches, or an automatic scan through registers 0..31. A value snapshot is taken once per refresh frame, so digits never show halves of two different values.

## Interface
- `SIZE`, 32, data width of `displayData`
- `ADDR_W`, 5, register index width
- `REFRESH_DIV`, 100000, clock cycles per digit slot (must be ≥ 1)
- `SCAN_DIV`, 100000000, dwell in clock cycles per register in auto-scan (must be ≥ 1)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `selReg`  in  ADDR_W  manual register select (switches)
- `pageSel`  in  1  0 = show bits [15:0], 1 = show bits [31:16]
- `autoScan`  in  1  1 = auto-scan mode, 0 = manual mode
- `displayReg`  out  ADDR_W  register index to the register file display port
- `displayData`  in  SIZE  combinational read data from the register file
- `an`  out  4  digit enables, active low, `an[0]` = rightmost digit
- `seg`  out  7  segments, active low, `seg[0]`=a … `seg[6]`=g
- `dp`  out  1  decimal point, active low

## Operation
- Refresh counter `rc` runs 0..REFRESH_DIV-1 and wraps.
  - Tick when `rc == REFRESH_DIV-1`.
  - On tick, digit index `d` advances mod 4.
- Frame boundary = tick with `d == 3`. At a frame boundary, all of the following happen in the same edge:
  - `snap <= displayData`
  - `pageLat <= pageSel`
  - `d <= 0`
- Manual mode (`autoScan=0`): `displayReg <= selReg` every cycle.
- Auto mode (`autoScan=1`):
  - Dwell counter `dc` runs 0..SCAN_DIV-1.
  - When `dc == SCAN_DIV-1`: `displayReg <= displayReg + 1`, wrapping 31 → 0.
  - On a 0 → 1 transition of `autoScan`, `dc` clears and scanning starts from the current `displayReg`.
  - On a 1 → 0 transition, the next edge loads `selReg`.
- Digit output:
  - `an[d] = 0`, all other bits of `an` = 1.
  - `seg` = hex glyph of nibble `d` of `snap[15:0]` when `pageLat=0`, or of `snap[31:16]` when `pageLat=1`.
  - `dp = 0` only when `pageLat=1` and `d=3`; otherwise `dp = 1`.
- Glyphs, as `seg[6:0]`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- `an`, `seg`, `dp` and `displayReg` are registered. All are updated from the previous cycle's state: 1-cycle latency after `d` or `snap` changes.
- Reset values, held while `reset=1`:
  - `displayReg=0`, `rc=0`, `dc=0`, `d=0`, `snap=0`, `pageLat=0`
  - `an=4'b1111`, `seg=7'b1111111`, `dp=1`
- First edge after reset release: `an=4'b1110`, `seg=7'b1000000`.
- Manual select to visible value: `displayReg` follows `selReg` after 1 cycle. The value appears on the first frame boundary after that, plus 1 cycle. Worst case is 2 + 4·REFRESH_DIV cycles.
- `displayData` or `pageSel` changes mid-frame do not alter the displayed digits until the next frame boundary.
- `displayReg` update and frame boundary on the same edge: `snap` captures `displayData` for the old index. The new index is picked up at the following frame.
- A `reset` assertion mid-frame or mid-dwell takes priority over every other event. The following edge produces the full reset state.
- `REFRESH_DIV=1`: the digit advances every cycle, and every 4th cycle is a frame boundary.

## Structure
- Shared package `display_pkg` holds:
  - the 16 glyph constants
  - `SEG_BLANK = 7'b1111111`
  - the digit-enable constants `AN_OFF = 4'b1111` and the one-hot-low patterns
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit glyph decoder using the package constants. The top instantiates it once, on the selected nibble.
- Top holds the counters, mode logic, snapshot and output registers.

## Test plan
All scenarios use `REFRESH_DIV=2` and `SCAN_DIV=8`. The bench models the register file combinationally: reg3=0x0000000C, reg5=0xDEADBEEF, reg30=0x0000001E, reg31=0x0000001F, all others 0.
- Reset: `reset=1` for 3 cycles → `an=1111`, `seg=1111111`, `dp=1`, `displayReg=0`. After release, `an=1110`, `seg=1000000`.
- Manual select: `selReg=3`, `pageSel=0` → `displayReg=3` after 1 cycle. After the next frame boundary:
  - `an=1110` shows `seg=1000110` (C)
  - `an=1101`, `1011`, `0111` show `seg=1000000` (0)
- Page select: `selReg=5`, `pageSel=1` → `an=0111`/`1011`/`1101`/`1110` show d/E/A/d = 0100001/0000110/0001000/0100001. `dp=0` only on `an=0111`.
- Auto-scan wrap: `selReg=30`, then `autoScan=1` → `displayReg` goes 30 → 31 after 8 cycles, then 31 → 0 after 16 cycles. The digit-0 glyph follows E, F, 0 (via reg30, reg31, reg0) at subsequent frames.
- Tear-free: change the reg3 value to 0x0000000F mid-frame → digit glyphs unchanged until the frame boundary. After it, digit 0 shows `0001110` (F).
- Reset mid-scan: assert `reset` at `displayReg=31` with `dc=5` → next edge gives `displayReg=0` and blank outputs. After release, `dc` restarts at 0, so the first increment happens 8 cycles later.
